// File: rtl/reg_bank_if.sv
// -----------------------------------------------------------------------------
// reg_bank_if
//   Command/response bundle for the eight-entry register bank.
//
//   Signals:
//     rd_en   read request (sampled on the rising clock edge)
//     ra, rb  read addresses for operand A / B
//     we      write enable (sampled on the rising clock edge)
//     wa, wd  write address / write data
//     clr     start a sequenced clear of r1..r7
//     qa, qb  registered operands A / B
//     q_valid one-cycle pulse: qa/qb were loaded by a read on the last edge
//     busy    clear sequence in progress
//
//   Modports:
//     master  drives commands, observes results (datapath control / bench)
//     slave   the register bank itself
// -----------------------------------------------------------------------------
interface reg_bank_if #(
  parameter int WIDTH = 8
);
  logic             rd_en;
  logic [2:0]       ra;
  logic [2:0]       rb;
  logic             we;
  logic [2:0]       wa;
  logic [WIDTH-1:0] wd;
  logic             clr;
  logic [WIDTH-1:0] qa;
  logic [WIDTH-1:0] qb;
  logic             q_valid;
  logic             busy;

  modport master (
    output rd_en, ra, rb, we, wa, wd, clr,
    input  qa, qb, q_valid, busy
  );

  modport slave (
    input  rd_en, ra, rb, we, wa, wd, clr,
    output qa, qb, q_valid, busy
  );
endinterface

// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
//   Eight-entry general-purpose register bank. r0 reads as zero and ignores
//   writes. A read request loads two registered operands (qa/qb) with
//   write-through bypass from a write on the same edge. A clr command walks a
//   pointer through r1..r7, zeroing one register per cycle while busy is high.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; zeroes the bank and all outputs
//     bus    reg_bank_if.slave (rd_en, ra, rb, we, wa, wd, clr -> qa, qb,
//            q_valid, busy)
// -----------------------------------------------------------------------------
module reg_bank #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_bank_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       cp_q;
  logic [2:0]       cp_d;

  // Entry 0 exists only so the array indexes cleanly with a 3-bit address;
  // it is reset to zero and never written.
  logic [WIDTH-1:0] bank [0:7];

  logic             wr_en;
  logic             clr_en;
  logic             vld_p0;
  logic [WIDTH-1:0] qa_p0;
  logic [WIDTH-1:0] qb_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] qa_p1;
  logic [WIDTH-1:0] qb_p1;

  // Operand value seen by a read on this edge: zero for r0, the incoming write
  // data when the same edge writes that register, otherwise the stored value.
  function automatic logic [WIDTH-1:0] operand(
    input logic [2:0]       addr,
    input logic             byp_en,
    input logic [2:0]       byp_addr,
    input logic [WIDTH-1:0] byp_data,
    input logic [WIDTH-1:0] stored
  );
    logic [WIDTH-1:0] v;
    if (addr == 3'd0)
      v = '0;
    else if (byp_en && (byp_addr == addr))
      v = byp_data;
    else
      v = stored;
    return v;
  endfunction

  // ---- stage p0: command decode, next state, operand selection ----
  always_comb begin
    state_d = state_q;
    cp_d    = cp_q;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    vld_p0  = 1'b0;
    case (state_q)
      IDLE: begin
        // A read on the clr edge still completes against pre-clear contents;
        // a write on that edge is dropped, so it cannot bypass either.
        vld_p0 = bus.rd_en;
        if (bus.clr) begin
          state_d = CLEAR;
          cp_d    = 3'd1;
        end else begin
          wr_en = bus.we && (bus.wa != 3'd0);
        end
      end
      CLEAR: begin
        clr_en = 1'b1;
        // cp stops at 7 rather than wrapping; it is only meaningful in CLEAR.
        if (cp_q == 3'd7)
          state_d = IDLE;
        else
          cp_d = cp_q + 3'd1;
      end
      default: begin
        state_d = IDLE;
        cp_d    = 3'd0;
      end
    endcase
    qa_p0 = operand(bus.ra, wr_en, bus.wa, bus.wd, bank[bus.ra]);
    qb_p0 = operand(bus.rb, wr_en, bus.wa, bus.wd, bank[bus.rb]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cp_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cp_q    <= cp_d;
    end
  end

  // Clearing takes priority, but wr_en is already low whenever clr_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++)
        bank[i] <= '0;
    end else if (clr_en) begin
      bank[cp_q] <= '0;
    end else if (wr_en) begin
      bank[bus.wa] <= bus.wd;
    end
  end

  // ---- stage p1: registered operands ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      qa_p1  <= '0;
      qb_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        qa_p1 <= qa_p0;
        qb_p1 <= qb_p0;
      end
    end
  end

  assign bus.qa      = qa_p1;
  assign bus.qb      = qb_p1;
  assign bus.q_valid = vld_p1;
  // busy is the state register itself, so it drops with the async reset.
  assign bus.busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_reg_bank
//   Directed bench for reg_bank: reset, write/read with r0, bypass, sequenced
//   clear, back-to-back reads, level-held clr and reset during a clear.
// -----------------------------------------------------------------------------
module tb_reg_bank;

  logic clk = 1'b0;
  logic rst_n;

  reg_bank_if #(.WIDTH(8)) bus ();

  reg_bank #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Advance one rising edge and settle; outputs are sampled here and the next
  // inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.rd_en = 1'b0;
    bus.ra    = 3'd0;
    bus.rb    = 3'd0;
    bus.we    = 1'b0;
    bus.wa    = 3'd0;
    bus.wd    = 8'h00;
    bus.clr   = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.we = 1'b1;
    bus.wa = a;
    bus.wd = d;
    tick();
    idle_in();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    #12;
    checks++; if (bus.qa !== 8'h00) begin errors++; $display("FAIL reset_qa: got %h expected %h", bus.qa, 8'h00); end
    checks++; if (bus.qb !== 8'h00) begin errors++; $display("FAIL reset_qb: got %h expected %h", bus.qb, 8'h00); end
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL reset_qvalid: got %b expected 0", bus.q_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release must accept a command.
    wr(3'd4, 8'h5A);
    bus.rd_en = 1'b1; bus.ra = 3'd4; bus.rb = 3'd7;
    tick();
    idle_in();
    checks++; if (bus.qa !== 8'h5A) begin errors++; $display("FAIL first_edge_write: got %h expected %h", bus.qa, 8'h5A); end
    checks++; if (bus.qb !== 8'h00) begin errors++; $display("FAIL reset_r7: got %h expected %h", bus.qb, 8'h00); end
    checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL reset_read_qvalid: got %b expected 1", bus.q_valid); end
  endtask

  task automatic test_write_read();
    wr(3'd5, 8'h3C);
    wr(3'd0, 8'hFF);
    bus.rd_en = 1'b1; bus.ra = 3'd5; bus.rb = 3'd0;
    tick();
    idle_in();
    checks++; if (bus.qa !== 8'h3C) begin errors++; $display("FAIL wr_rd_qa: got %h expected %h", bus.qa, 8'h3C); end
    checks++; if (bus.qb !== 8'h00) begin errors++; $display("FAIL r0_zero: got %h expected %h", bus.qb, 8'h00); end
    checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_qvalid: got %b expected 1", bus.q_valid); end
    tick();
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL idle_qvalid: got %b expected 0", bus.q_valid); end
    checks++; if (bus.qa !== 8'h3C) begin errors++; $display("FAIL idle_qa_hold: got %h expected %h", bus.qa, 8'h3C); end
  endtask

  task automatic test_bypass();
    wr(3'd6, 8'h11);
    bus.we = 1'b1; bus.wa = 3'd6; bus.wd = 8'h81;
    bus.rd_en = 1'b1; bus.ra = 3'd6; bus.rb = 3'd6;
    tick();
    idle_in();
    checks++; if (bus.qa !== 8'h81) begin errors++; $display("FAIL bypass_qa: got %h expected %h", bus.qa, 8'h81); end
    checks++; if (bus.qb !== 8'h81) begin errors++; $display("FAIL bypass_qb: got %h expected %h", bus.qb, 8'h81); end
    // Bypass on port B only, port A reads the earlier bypassed write.
    bus.we = 1'b1; bus.wa = 3'd5; bus.wd = 8'h42;
    bus.rd_en = 1'b1; bus.ra = 3'd6; bus.rb = 3'd5;
    tick();
    idle_in();
    checks++; if (bus.qa !== 8'h81) begin errors++; $display("FAIL bypass_persist: got %h expected %h", bus.qa, 8'h81); end
    checks++; if (bus.qb !== 8'h42) begin errors++; $display("FAIL bypass_portb: got %h expected %h", bus.qb, 8'h42); end
  endtask

  task automatic test_clear();
    for (int n = 1; n < 8; n++) wr(3'(n), 8'(n));
    bus.clr = 1'b1;
    bus.we = 1'b1; bus.wa = 3'd2; bus.wd = 8'hEE;
    bus.rd_en = 1'b1; bus.ra = 3'd7; bus.rb = 3'd2;
    tick();
    checks++; if (bus.qa !== 8'h07) begin errors++; $display("FAIL clr_edge_qa: got %h expected %h", bus.qa, 8'h07); end
    checks++; if (bus.qb !== 8'h02) begin errors++; $display("FAIL clr_edge_qb: got %h expected %h", bus.qb, 8'h02); end
    checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL clr_edge_qvalid: got %b expected 1", bus.q_valid); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clr_busy_0: got %b expected 1", bus.busy); end
    // Commands while busy must be ignored; writes target r1, which is
    // cleared first, so any leaked write would survive the sequence.
    bus.clr = 1'b0;
    for (int k = 1; k < 8; k++) begin
      bus.we = 1'b1; bus.wa = 3'd1; bus.wd = 8'hEE;
      bus.rd_en = 1'b1; bus.ra = 3'd1; bus.rb = 3'd1;
      tick();
      checks++; if (bus.busy !== (k < 7)) begin errors++; $display("FAIL clr_busy_%0d: got %b expected %b", k, bus.busy, (k < 7)); end
      checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL clr_qvalid_%0d: got %b expected 0", k, bus.q_valid); end
      checks++; if (bus.qa !== 8'h07) begin errors++; $display("FAIL clr_qa_hold_%0d: got %h expected %h", k, bus.qa, 8'h07); end
    end
    idle_in();
    for (int i = 1; i < 8; i++) begin
      bus.rd_en = 1'b1; bus.ra = 3'(i); bus.rb = 3'(i);
      tick();
      checks++; if (bus.qa !== 8'h00) begin errors++; $display("FAIL cleared_r%0d: got %h expected %h", i, bus.qa, 8'h00); end
    end
    idle_in();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v [8];
    exp_v = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    for (int n = 1; n < 8; n++) wr(3'(n), 8'(8'h10 + n));
    for (int i = 0; i < 8; i++) begin
      bus.rd_en = 1'b1; bus.ra = 3'(i); bus.rb = 3'(7 - i);
      tick();
      checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL b2b_qvalid_%0d: got %b expected 1", i, bus.q_valid); end
      checks++; if (bus.qa !== exp_v[i]) begin errors++; $display("FAIL b2b_qa_%0d: got %h expected %h", i, bus.qa, exp_v[i]); end
      checks++; if (bus.qb !== exp_v[7 - i]) begin errors++; $display("FAIL b2b_qb_%0d: got %h expected %h", i, bus.qb, exp_v[7 - i]); end
    end
    idle_in();
  endtask

  task automatic test_clr_level();
    logic exp_busy [10];
    int   waited;
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    bus.clr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (bus.busy !== exp_busy[k]) begin errors++; $display("FAIL level_busy_%0d: got %b expected %b", k, bus.busy, exp_busy[k]); end
    end
    idle_in();
    waited = 0;
    while (bus.busy === 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL level_drain: got busy %b expected 0 within 20 cycles", bus.busy); end
  endtask

  task automatic test_reset_mid();
    wr(3'd3, 8'hA5);
    bus.clr = 1'b1; bus.rd_en = 1'b1; bus.ra = 3'd3; bus.rb = 3'd3;
    tick();
    idle_in();
    checks++; if (bus.qa !== 8'hA5) begin errors++; $display("FAIL mid_pre_qa: got %h expected %h", bus.qa, 8'hA5); end
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy_async: got %b expected 0", bus.busy); end
    checks++; if (bus.qa !== 8'h00) begin errors++; $display("FAIL mid_qa: got %h expected %h", bus.qa, 8'h00); end
    checks++; if (bus.qb !== 8'h00) begin errors++; $display("FAIL mid_qb: got %h expected %h", bus.qb, 8'h00); end
    checks++; if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL mid_qvalid: got %b expected 0", bus.q_valid); end
    tick();
    rst_n = 1'b1;
    bus.rd_en = 1'b1; bus.ra = 3'd3; bus.rb = 3'd7;
    tick();
    idle_in();
    checks++; if (bus.qa !== 8'h00) begin errors++; $display("FAIL mid_r3: got %h expected %h", bus.qa, 8'h00); end
    checks++; if (bus.qb !== 8'h00) begin errors++; $display("FAIL mid_r7: got %h expected %h", bus.qb, 8'h00); end
    checks++; if (bus.q_valid !== 1'b1) begin errors++; $display("FAIL mid_read_qvalid: got %b expected 1", bus.q_valid); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_back_to_back();
    test_clr_level();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Eight-entry general-purpose register bank for the RISC datapath. It stores the architectural registers and produces two registered operand words per read request. These operands feed the bit-slice Mux2b/Mux4b/Mux8b selection network directly downstream. It also provides a single-command sequenced clear of the whole bank, used after boot and on pipeline flush.

## Interface
- WIDTH, 8, data width of every register and of the read/write data ports
- clk  input  1  rising-edge clock, only clock in the block
- rst_n  input  1  reset, asynchronous and active-low
- rd_en  input  1  read request, sampled on clk rising edge
- ra  input  3  read address, port A
- rb  input  3  read address, port B
- we  input  1  write enable, sampled on clk rising edge
- wa  input  3  write address
- wd  input  WIDTH  write data
- clr  input  1  start sequenced clear of r1..r7 (single-cycle pulse or level; only the sampled edge matters)
- qa  output  WIDTH  registered operand A
- qb  output  WIDTH  registered operand B
- q_valid  output  1  qa/qb updated by a read on the last edge (one-cycle pulse per accepted read)
- busy  output  1  clear sequence in progress

## Operation
- Storage: r0..r7, WIDTH bits each. r0 is hardwired zero: reads of address 0 return 0, and writes to address 0 are discarded.
- States: IDLE, CLEAR. A 3-bit clear pointer cp is used only in CLEAR.
- IDLE, we=1, wa!=0: r[wa] <= wd on the edge.
- IDLE, rd_en=1: qa <= value(ra) and qb <= value(rb) on the edge; q_valid <= 1.
  - value(x) = 0 if x==0.
  - Otherwise, value(x) = wd if we=1 && wa==x on that same edge (write-through bypass).
  - Otherwise, value(x) = r[x].
- IDLE, rd_en=0: q_valid <= 0. qa/qb hold their last values.
- IDLE, clr=1: go to CLEAR with cp <= 1 and busy <= 1.
  - A write sampled on the same edge is dropped.
  - A read sampled on the same edge is performed, using pre-clear contents (bypass does not apply, because the write is dropped).
- CLEAR, each edge: r[cp] <= 0 and cp <= cp+1.
  - When cp==7, r7 is cleared, the state returns to IDLE and busy <= 0. cp never wraps to 0.
- CLEAR: we, rd_en and clr are ignored; q_valid is held 0; qa/qb hold.
- The bank contents are never X after reset; there are no uninitialised reads.

## Timing
- Reset (rst_n low, asynchronous, regardless of clk):
  - r1..r7 = 0, qa = 0, qb = 0, q_valid = 0, busy = 0, state = IDLE, cp = 0.
  - Release is synchronous to the next rising edge; the first edge with rst_n high may accept a command.
- Reset asserted mid-CLEAR: the bank is fully zeroed immediately, busy drops asynchronously and the state returns to IDLE.
- Read latency: request sampled at edge N; qa/qb/q_valid are valid after edge N, for cycle N..N+1. Back-to-back reads give one result per cycle, and q_valid stays high continuously.
- Write latency: a write at edge N is visible to a read sampled at edge N (bypass) and at any later edge.
- Simultaneous read and write to the same nonzero address: the read returns the new wd on both ports if both addresses match.
- Clear: clr sampled at edge N gives busy=1 after edge N. r1 is cleared at edge N+1 and r7 at edge N+7. busy=0 after edge N+7, so busy is high for exactly 7 cycles. The first new command is accepted at edge N+8.
- clr held high at edge N+8 starts a new sequence (level-sensitive in IDLE).

## Test plan
- Reset mid-sequence:
  - Stimulus: write r3=0xA5; pulse clr; assert rst_n low two edges later, then release.
  - Required: busy=0 immediately; qa=qb=0, q_valid=0; a read of ra=3, rb=7 returns 0x00/0x00 with q_valid=1 one edge later.
- Write-then-read and r0:
  - Stimulus: write r5=0x3C at edge 1; write r0=0xFF at edge 2; read ra=5, rb=0 at edge 3.
  - Required: after edge 3, qa=0x3C, qb=0x00, q_valid=1; after edge 4 (rd_en=0), q_valid=0 and qa still 0x3C.
- Bypass:
  - Stimulus: in the same cycle, we=1, wa=6, wd=0x81, rd_en=1, ra=6, rb=6; r6 previously 0x11.
  - Required: after the edge, qa=qb=0x81; a following read of r6 also returns 0x81.
- Clear sequence:
  - Stimulus: load r1..r7 with 0x01..0x07; pulse clr together with we (wa=2, wd=0xEE) and rd_en (ra=7).
  - Required: qa=0x07 and q_valid=1 after the clr edge; busy high exactly 7 cycles; we/rd_en toggled during busy have no effect (q_valid=0); afterwards r1..r7 all read 0x00 and r2 is not 0xEE.
- Back-to-back reads:
  - Stimulus: 8 consecutive reads with ra=0..7, rb=7..0 after loading rN=0x10+N for N=1..7.
  - Required: q_valid high for 8 consecutive cycles; qa/qb track each request with 1-cycle latency (e.g. the third result is qa=0x12, qb=0x15).
- clr level held:
  - Stimulus: hold clr=1 for 10 cycles from IDLE.
  - Required: busy high for 7 cycles, low for 1 cycle, then high again (second sequence starts at edge N+8).
